sync_ram_cfg: RTL and testbench
===============================

# sync_ram_cfg

Parametrised successor to the single-port-pair sync RAM block: a simple dual-port synchronous RAM with per-lane write enables, a selectable read-during-write policy, an optional output register stage and a hardware initialisation sweep after reset. It backs the Sobel line buffers and any other frame-path storage that must start from a known value without a host-side clear pass.

## Interface
- WIDTH_P, 16, data word width; must be a multiple of LANE_W_P
- DEPTH_P, 16, number of words; need not be a power of two; minimum 2
- LANE_W_P, 8, bits per write lane; LANES = WIDTH_P/LANE_W_P
- RDW_MODE_P, RDW_READ_FIRST, same-address read-during-write policy (RDW_READ_FIRST or RDW_WRITE_FIRST)
- OUT_REG_P, 0, 0: read latency 1; 1: extra output register, read latency 2
- INIT_ON_RESET_P, 1, 1: sweep INIT_VAL_P into every word after reset; 0: no sweep, contents undefined
- INIT_VAL_P, '0, word value written by the sweep
- clk_i  in  1  sole clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- wr_en_i  in  1  write request
- wr_addr_i  in  AW = max(1,$clog2(DEPTH_P))  write address
- wr_data_i  in  WIDTH_P  write data
- wr_be_i  in  LANES  per-lane write enable; bit k covers bits [k*LANE_W_P +: LANE_W_P]
- rd_en_i  in  1  read request
- rd_addr_i  in  AW  read address
- rd_data_o  out  WIDTH_P  read data; holds last value when no new read completes
- rd_valid_o  out  1  one-cycle pulse marking rd_data_o as new
- init_busy_o  out  1  high while sweep is in progress; all requests ignored

## Operation
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- States: INIT, RUN. rst_i high forces INIT with sweep counter 0 (or RUN if INIT_ON_RESET_P=0).
- INIT: each cycle writes INIT_VAL_P to address = counter, counter increments; after writing DEPTH_P-1 move to RUN. wr_en_i/rd_en_i ignored; no rd_valid_o.
- RUN: write on wr_en_i, only lanes with wr_be_i set; wr_be_i all zero is a no-op. Read on rd_en_i.
- Same-address, same-cycle rd/wr: READ_FIRST returns pre-write word; WRITE_FIRST returns merged word (new data on enabled lanes, old data elsewhere). Different addresses never interact.
- Address >= DEPTH_P (non-power-of-two depth): write dropped; read returns 0 with rd_valid_o asserted.
- Reads fully pipelined: one read accepted per cycle, no stall, no backpressure.

## Timing
- Reset values: rd_data_o = 0, rd_valid_o = 0, output-register stage cleared, init_busy_o = 1 if INIT_ON_RESET_P else 0.
- Sweep: edge E0 samples rst_i high; edges E1..E_DEPTH_P write addresses 0..DEPTH_P-1; init_busy_o falls after E_DEPTH_P; first request accepted at E_DEPTH_P+1. init_busy_o high exactly DEPTH_P cycles after rst_i drops.
- Read accepted at edge N: rd_data_o/rd_valid_o update at edge N (OUT_REG_P=0) or N+1 (OUT_REG_P=1), i.e. visible the cycle after, or two cycles after, the request cycle.
- Write at edge N visible to a read accepted at edge N+1 in either mode.
- rst_i mid-operation: in-flight reads discarded (rd_valid_o=0 next cycle), rd_data_o=0, sweep restarts from address 0.

## Structure
- Package sync_ram_cfg_pkg: rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST}, state enum {ST_INIT, ST_RUN}, lane-count/address-width helper functions.
- Sub-module sync_ram_init_seq: INIT/RUN FSM and sweep counter, outputs sweep address, sweep write strobe, init_busy_o. Top muxes sweep vs. user write port into the array.
- Array inferred as block RAM; lane enables via per-lane write loop; no reset on the array itself.

## Test plan
- Init sweep (WIDTH_P=16, DEPTH_P=16, INIT_VAL_P=0): rst_i high 2 cycles -> init_busy_o high exactly 16 cycles; reads of addresses 0..15 all return 0x0000, rd_valid_o one cycle after each rd_en_i.
- Lanes: write 0xA5A5 to addr 3 with be=2'b11, then 0x12FF with be=2'b10 -> read addr 3 returns 0x12A5; write with be=2'b00 leaves 0x12A5.
- Read-during-write: addr 0 holds 0x0007, same cycle write 0x000D + read addr 0 -> READ_FIRST returns 0x0007 then next read 0x000D; WRITE_FIRST returns 0x000D immediately.
- OUT_REG_P=1: addresses 1,2,3 hold 0x0011,0x0022,0x0033, back-to-back reads -> rd_valid_o high 3 consecutive cycles starting two cycles after first request, data 0x0011,0x0022,0x0033.
- Requests during init: wr_en_i addr 2 data 0xBEEF and rd_en_i asserted during sweep -> rd_valid_o stays 0; after init addr 2 reads 0x0000.
- Reset mid-read (OUT_REG_P=1, DEPTH_P=12): rst_i one cycle while read of addr 5 in flight -> rd_valid_o 0, rd_data_o 0, init_busy_o high 12 cycles, addr 5 reads 0x0000; read of addr 13 returns 0 with rd_valid_o=1.

Source files
------------

// File: rtl/sync_ram_cfg_pkg.sv
// Shared types and sizing helpers for the configurable dual-port sync RAM.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sync_ram_cfg_pkg;

  // Result of a read and a write to the same address in the same cycle.
  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,  // read returns the word as it was before the write
    RDW_WRITE_FIRST = 1'b1   // read returns the word with the write merged in
  } rdw_mode_e;

  // Initialisation sequencer states.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of independently writable lanes in a word.
  function automatic int lanes_f(input int width, input int lane_w);
    return width / lane_w;
  endfunction

  // Address width, never below one bit even for tiny depths.
  function automatic int addr_w_f(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_ram_init_seq.sv
// INIT/RUN sequencer: after reset, sweeps one address per cycle to clear the array.
// Latency: DEPTH_P cycles of init_busy_o after reset is released.
// Backpressure: none; init_busy_o tells the top to ignore user requests.
// Ports: clk_i/rst_i (sync, active-high); sweep_addr/sweep_we drive the array
// write port while init_busy_o is high.
module sync_ram_init_seq
  import sync_ram_cfg_pkg::*;
#(
  parameter int DEPTH_P         = 16,
  parameter int AW_P            = 4,
  parameter bit INIT_ON_RESET_P = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [AW_P-1:0] sweep_addr,
  output logic            sweep_we,
  output logic            init_busy_o
);

  localparam logic [AW_P-1:0] LAST_ADDR = AW_P'(DEPTH_P - 1);

  state_e state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sweep_addr <= '0;
      if (INIT_ON_RESET_P) begin
        state       <= ST_INIT;
        init_busy_o <= 1'b1;
      end else begin
        state       <= ST_RUN;
        init_busy_o <= 1'b0;
      end
    end else begin
      case (state)
        ST_INIT: begin
          // The write to LAST_ADDR happens on this same edge, so busy can drop now.
          if (sweep_addr == LAST_ADDR) begin
            state       <= ST_RUN;
            init_busy_o <= 1'b0;
            sweep_addr  <= '0;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        default: begin
          init_busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Busy is exactly the window in which the sweep owns the write port.
  assign sweep_we = init_busy_o;

endmodule

// File: rtl/sync_ram_cfg.sv
// Simple dual-port sync RAM: lane write enables, selectable read-during-write, optional out reg, init sweep.
// Latency: read data 1 cycle after request (2 with OUT_REG_P=1); write visible to the next cycle's read.
// Backpressure: none; one read and one write per cycle, requests ignored while init_busy_o is high.
// Ports: clk_i/rst_i (sync, active-high); wr_en_i/wr_addr_i/wr_data_i/wr_be_i write port;
// rd_en_i/rd_addr_i read request; rd_data_o/rd_valid_o read result; init_busy_o sweep in progress.
module sync_ram_cfg
  import sync_ram_cfg_pkg::*;
#(
  parameter int                 WIDTH_P         = 16,
  parameter int                 DEPTH_P         = 16,
  parameter int                 LANE_W_P        = 8,
  parameter rdw_mode_e          RDW_MODE_P      = RDW_READ_FIRST,
  parameter bit                 OUT_REG_P       = 1'b0,
  parameter bit                 INIT_ON_RESET_P = 1'b1,
  parameter logic [WIDTH_P-1:0] INIT_VAL_P      = '0,
  localparam int                LANES           = lanes_f(WIDTH_P, LANE_W_P),
  localparam int                AW              = addr_w_f(DEPTH_P)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [WIDTH_P-1:0] wr_data_i,
  input  logic [LANES-1:0]   wr_be_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [WIDTH_P-1:0] rd_data_o,
  output logic               rd_valid_o,
  output logic               init_busy_o
);

  // One extra bit so a non-power-of-two depth compares cleanly against the address.
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH_P);

  logic [WIDTH_P-1:0] mem [DEPTH_P];

  logic [AW-1:0]      sweep_addr;
  logic               sweep_we;

  logic               run_ok;
  logic               wr_ok;
  logic               rd_ok;
  logic               rd_in_range;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [WIDTH_P-1:0] mem_wdat;
  logic [LANES-1:0]   mem_be;
  logic [WIDTH_P-1:0] rd_word;

  logic [WIDTH_P-1:0] s1_dat;
  logic               s1_vld;

  sync_ram_init_seq #(
    .DEPTH_P         (DEPTH_P),
    .AW_P            (AW),
    .INIT_ON_RESET_P (INIT_ON_RESET_P)
  ) u_init_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sweep_addr  (sweep_addr),
    .sweep_we    (sweep_we),
    .init_busy_o (init_busy_o)
  );

  // User traffic is only honoured in RUN and outside the reset cycle.
  assign run_ok      = !rst_i && !init_busy_o;
  assign wr_ok       = run_ok && wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L);
  assign rd_ok       = run_ok && rd_en_i;
  assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_L);

  // Sweep and user port share the single array write port.
  assign mem_we   = !rst_i && (sweep_we || wr_ok);
  assign mem_addr = sweep_we ? sweep_addr : wr_addr_i;
  assign mem_wdat = sweep_we ? INIT_VAL_P : wr_data_i;
  assign mem_be   = sweep_we ? {LANES{1'b1}} : wr_be_i;

  // Array has no reset; contents come from the sweep or the user.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < LANES; k++) begin
        if (mem_be[k]) begin
          mem[mem_addr][k*LANE_W_P +: LANE_W_P] <= mem_wdat[k*LANE_W_P +: LANE_W_P];
        end
      end
    end
  end

  // Read word as seen by this cycle's request. Out-of-range reads return zero.
  // Write-first forwards enabled lanes of a same-address write in the same cycle.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr_i];
      if (RDW_MODE_P == RDW_WRITE_FIRST && wr_ok && (wr_addr_i == rd_addr_i)) begin
        for (int k = 0; k < LANES; k++) begin
          if (wr_be_i[k]) begin
            rd_word[k*LANE_W_P +: LANE_W_P] = wr_data_i[k*LANE_W_P +: LANE_W_P];
          end
        end
      end
    end
  end

  // First read stage; data holds until the next accepted read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_dat <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= rd_ok;
      if (rd_ok) begin
        s1_dat <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG_P) begin : g_out_reg
      logic [WIDTH_P-1:0] s2_dat;
      logic               s2_vld;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s2_dat <= '0;
          s2_vld <= 1'b0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_dat <= s1_dat;
          end
        end
      end

      assign rd_data_o  = s2_dat;
      assign rd_valid_o = s2_vld;
    end else begin : g_no_out_reg
      assign rd_data_o  = s1_dat;
      assign rd_valid_o = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_sync_ram_cfg.sv
// Directed bench for sync_ram_cfg: three instances share one stimulus stream.
//   u_a: depth 16, read-first, no output register
//   u_b: depth 16, write-first, no output register
//   u_c: depth 12, read-first, output register
module tb_sync_ram_cfg;
  import sync_ram_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [15:0] rd_data_a, rd_data_b, rd_data_c;
  logic        rd_valid_a, rd_valid_b, rd_valid_c;
  logic        busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_ram_cfg #(
    .WIDTH_P(16), .DEPTH_P(16), .LANE_W_P(8), .RDW_MODE_P(RDW_READ_FIRST),
    .OUT_REG_P(1'b0), .INIT_ON_RESET_P(1'b1), .INIT_VAL_P(16'h0000)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_valid_o(rd_valid_a), .init_busy_o(busy_a)
  );

  sync_ram_cfg #(
    .WIDTH_P(16), .DEPTH_P(16), .LANE_W_P(8), .RDW_MODE_P(RDW_WRITE_FIRST),
    .OUT_REG_P(1'b0), .INIT_ON_RESET_P(1'b1), .INIT_VAL_P(16'h0000)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_valid_o(rd_valid_b), .init_busy_o(busy_b)
  );

  sync_ram_cfg #(
    .WIDTH_P(16), .DEPTH_P(12), .LANE_W_P(8), .RDW_MODE_P(RDW_READ_FIRST),
    .OUT_REG_P(1'b1), .INIT_ON_RESET_P(1'b1), .INIT_VAL_P(16'h0000)
  ) u_c (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_c),
    .rd_valid_o(rd_valid_c), .init_busy_o(busy_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    tick();
    wr_en   = 1'b0;
  endtask

  // Release reset and measure how many edges each busy flag stays high (bounded).
  task automatic measure_init(output int fa, output int fc, input bit poke);
    bit saw_vld;
    fa = 0;
    fc = 0;
    saw_vld = 1'b0;
    rst = 1'b0;
    if (poke) begin
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hBEEF; wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = 4'd2;
    end
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 8) idle_inputs();
      if (rd_valid_a || rd_valid_b || rd_valid_c) saw_vld = 1'b1;
      if (!busy_a && fa == 0) fa = i;
      if (!busy_c && fc == 0) fc = i;
    end
    chk("no_valid_during_init", saw_vld, 1'b0);
  endtask

  initial begin
    int fa, fc;
    idle_inputs();
    rst = 1'b1;

    // Reset state after the first reset edge.
    tick();
    chk("rst_valid_a", rd_valid_a, 1'b0);
    chk("rst_data_a", rd_data_a, 16'h0000);
    chk("rst_busy_a", busy_a, 1'b1);
    chk("rst_valid_c", rd_valid_c, 1'b0);
    chk("rst_busy_c", busy_c, 1'b1);
    tick();

    // Init sweep with write/read requests asserted during it.
    measure_init(fa, fc, 1'b1);
    chk("init_len_a16", fa, 16);
    chk("init_len_c12", fc, 12);

    // Every word cleared; address 2 must not hold the ignored 0xBEEF.
    for (int k = 0; k < 16; k++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(k);
      tick();
      chk($sformatf("sweep_vld_a%0d", k), rd_valid_a, 1'b1);
      chk($sformatf("sweep_dat_a%0d", k), rd_data_a, 16'h0000);
      chk($sformatf("sweep_dat_b%0d", k), rd_data_b, 16'h0000);
    end
    rd_en = 1'b0;
    tick();
    chk("idle_vld_a", rd_valid_a, 1'b0);

    // Lane enables.
    wr(4'd3, 16'hA5A5, 2'b11);
    wr(4'd3, 16'h12FF, 2'b10);
    wr(4'd3, 16'h5555, 2'b00);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("lane_dat_a", rd_data_a, 16'h12A5);
    chk("lane_vld_a", rd_valid_a, 1'b1);
    chk("lane_dat_b", rd_data_b, 16'h12A5);
    chk("lane_vld_c_lat1", rd_valid_c, 1'b0);
    tick();
    chk("lane_vld_c", rd_valid_c, 1'b1);
    chk("lane_dat_c", rd_data_c, 16'h12A5);
    chk("hold_dat_a", rd_data_a, 16'h12A5);
    chk("hold_vld_a", rd_valid_a, 1'b0);

    // Same-address read during write.
    wr(4'd0, 16'h0007, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h000D; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    wr_en = 1'b0;
    chk("rdw_read_first", rd_data_a, 16'h0007);
    chk("rdw_write_first", rd_data_b, 16'h000D);
    tick();
    rd_en = 1'b0;
    chk("rdw_next_a", rd_data_a, 16'h000D);
    chk("rdw_next_b", rd_data_b, 16'h000D);

    // Output register: back-to-back reads of 1,2,3.
    wr(4'd1, 16'h0011, 2'b11);
    wr(4'd2, 16'h0022, 2'b11);
    wr(4'd3, 16'h0033, 2'b11);
    rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    chk("oreg_vld_t1", rd_valid_c, 1'b0);
    rd_addr = 4'd2;
    tick();
    chk("oreg_vld_t2", rd_valid_c, 1'b1);
    chk("oreg_dat_t2", rd_data_c, 16'h0011);
    rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("oreg_vld_t3", rd_valid_c, 1'b1);
    chk("oreg_dat_t3", rd_data_c, 16'h0022);
    tick();
    chk("oreg_vld_t4", rd_valid_c, 1'b1);
    chk("oreg_dat_t4", rd_data_c, 16'h0033);
    tick();
    chk("oreg_vld_t5", rd_valid_c, 1'b0);
    chk("oreg_hold_t5", rd_data_c, 16'h0033);

    // Reset while a read of address 5 is in flight in u_c.
    wr(4'd5, 16'h5555, 2'b11);
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    chk("pre_rst_dat_a", rd_data_a, 16'h5555);
    rst = 1'b1;
    tick();
    chk("mid_rst_vld_c", rd_valid_c, 1'b0);
    chk("mid_rst_dat_c", rd_data_c, 16'h0000);
    chk("mid_rst_dat_a", rd_data_a, 16'h0000);
    measure_init(fa, fc, 1'b0);
    chk("reinit_len_c12", fc, 12);
    chk("reinit_len_a16", fa, 16);

    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    chk("reinit_dat_a5", rd_data_a, 16'h0000);
    tick();
    chk("reinit_vld_c5", rd_valid_c, 1'b1);
    chk("reinit_dat_c5", rd_data_c, 16'h0000);

    // Out-of-range address on the depth-12 instance.
    wr(4'd13, 16'hFFFF, 2'b11);
    wr(4'd7, 16'h7777, 2'b11);
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    rd_addr = 4'd13;
    tick();
    rd_en = 1'b0;
    chk("oor_dat_a13", rd_data_a, 16'hFFFF);
    chk("pre_oor_dat_c7", rd_data_c, 16'h7777);
    tick();
    chk("oor_vld_c13", rd_valid_c, 1'b1);
    chk("oor_dat_c13", rd_data_c, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
